// File: rtl/aes_round_ctrl_pkg.sv
// Shared encodings for the AES round sequencer.
//   - datapath opcodes driven on op
//   - key-size mode encodings sampled from mode
//   - FSM state encodings (also visible on dbg_state)
//   - nr_of(): number of rounds Nr for a given key-size mode
package aes_round_ctrl_pkg;

    localparam logic [1:0] OP_NOP   = 2'd0;  // datapath idle
    localparam logic [1:0] OP_ARK   = 2'd1;  // AddRoundKey only
    localparam logic [1:0] OP_ROUND = 2'd2;  // full round
    localparam logic [1:0] OP_FINAL = 2'd3;  // last round, no MixColumns

    localparam logic [1:0] MODE_128  = 2'd0;
    localparam logic [1:0] MODE_192  = 2'd1;
    localparam logic [1:0] MODE_256  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARK   = 3'd1;
    localparam logic [2:0] ST_ROUND = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Reserved mode is never latched, so its table entry is never used.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            MODE_128: nr = 4'd10;
            MODE_192: nr = 4'd12;
            MODE_256: nr = 4'd14;
            default:  nr = 4'd10;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round counter for the AES sequencer.
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_clr    clear to round 0 (dominates i_inc)
//   i_inc    advance one round
//   i_nr     number of rounds for the active key size
//   o_round  current round number
//   o_tc     high while o_round == i_nr-1 (last full round before FINAL)
module aes_round_counter #(
    parameter int W_RND = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [W_RND-1:0] i_nr,
    output logic [W_RND-1:0] o_round,
    output logic             o_tc
);

    logic [W_RND-1:0] r_round;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_round <= '0;
        end else if (i_inc) begin
            r_round <= r_round + W_RND'(1);
        end
    end

    assign o_round = r_round;
    assign o_tc    = (r_round == (i_nr - W_RND'(1)));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steers a register-file datapath through
// ARK -> ROUND x (Nr-1) -> FINAL for AES-128/192/256.
//   clk, rst_n          clock and synchronous active-low reset
//   start, mode         request and key size (mode 3 is rejected via err)
//   src_sel, key_base,
//   dst_sel             plaintext / round-key-0 / destination registers
//   abort               cancel a running operation
//   data_reg, key_reg   register-file read selects
//   op, wr_en, wr_reg   datapath opcode and write-back control
//   round               current round number
//   busy, done, err     status; done and err are one-cycle pulses
//   dbg_state           current FSM state
//
// Handshake: start is a level sampled only in IDLE; an accepted start is
// acknowledged implicitly by busy rising next cycle and completion by a
// one-cycle done pulse; a start seen while busy or in DONE is dropped.
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int W_IDX = 4,
    parameter int W_RND = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [W_IDX-1:0] src_sel,
    input  logic [W_IDX-1:0] key_base,
    input  logic [W_IDX-1:0] dst_sel,
    input  logic             abort,
    output logic [W_IDX-1:0] data_reg,
    output logic [W_IDX-1:0] key_reg,
    output logic [1:0]       op,
    output logic             wr_en,
    output logic [W_IDX-1:0] wr_reg,
    output logic [W_RND-1:0] round,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    logic [2:0]       r_state;
    logic [1:0]       r_mode;
    logic [W_IDX-1:0] r_src;
    logic [W_IDX-1:0] r_key;
    logic [W_IDX-1:0] r_dst;
    logic             r_err;

    logic             w_busy;
    logic             w_in_seq;
    logic             w_clr;
    logic             w_inc;
    logic             w_tc;
    logic [W_RND-1:0] w_nr;
    logic [W_RND-1:0] w_round;
    logic [W_IDX-1:0] w_key;

    assign w_nr     = W_RND'(nr_of(r_mode));
    assign w_busy   = (r_state == ST_ARK) || (r_state == ST_ROUND) || (r_state == ST_FINAL);
    // The counter advances out of ARK and every ROUND, so it already holds Nr
    // when FINAL is entered. Abort clears it so an immediate restart begins at 0.
    assign w_in_seq = (r_state == ST_ARK) || (r_state == ST_ROUND);
    assign w_inc    = w_in_seq && !abort;
    assign w_clr    = !w_in_seq || abort;
    // Key index wraps modulo the register-file size.
    assign w_key    = r_key + W_IDX'(w_round);

    aes_round_counter #(.W_RND(W_RND)) u_counter (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_nr    (w_nr),
        .o_round (w_round),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= '0;
            r_src   <= '0;
            r_key   <= '0;
            r_dst   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_RSVD) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode  <= mode;
                            r_src   <= src_sel;
                            r_key   <= key_base;
                            r_dst   <= dst_sel;
                            r_state <= ST_ARK;
                        end
                    end
                end
                ST_ARK:   r_state <= abort ? ST_IDLE : ST_ROUND;
                ST_ROUND: begin
                    if (abort)     r_state <= ST_IDLE;
                    else if (w_tc) r_state <= ST_FINAL;
                end
                ST_FINAL: r_state <= abort ? ST_IDLE : ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        op       = OP_NOP;
        data_reg = '0;
        key_reg  = '0;
        wr_reg   = '0;
        round    = '0;
        case (r_state)
            ST_ARK:   begin op = OP_ARK;   data_reg = r_src; end
            ST_ROUND: begin op = OP_ROUND; data_reg = r_dst; end
            ST_FINAL: begin op = OP_FINAL; data_reg = r_dst; end
            default:  begin op = OP_NOP;   data_reg = '0;    end
        endcase
        if (w_busy) begin
            key_reg = w_key;
            wr_reg  = r_dst;
            round   = w_round;
        end
    end

    // Abort suppresses the write in the same cycle it is raised.
    assign wr_en     = w_busy && !abort;
    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: W_IDX, 4, register-file index width (16 registers).
REQ-002 Parameter: W_RND, 4, round counter width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request, sampled only in IDLE.
REQ-006 mode  in  2  key size: 0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=reserved.
REQ-007 src_sel  in  W_IDX  register holding plaintext state.
REQ-008 key_base  in  W_IDX  register holding round key 0; round key r lives at key_base+r mod 16.
REQ-009 dst_sel  in  W_IDX  register receiving intermediate and final state.
REQ-010 abort  in  1  cancel the operation in progress.
REQ-011 data_reg  out  W_IDX  register-file data read select.
REQ-012 key_reg  out  W_IDX  register-file key read select.
REQ-013 op  out  2  datapath op: 0=NOP, 1=ARK (AddRoundKey only), 2=ROUND, 3=FINAL (no MixColumns).
REQ-014 wr_en  out  1  write datapath result into wr_reg this cycle.
REQ-015 wr_reg  out  W_IDX  write destination.
REQ-016 round  out  W_RND  current round number.
REQ-017 busy  out  1  operation in progress.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-020 States SHALL be IDLE, ARK, ROUND, FINAL and DONE.
REQ-021 IDLE, start=1, mode!=3: latch mode, src_sel, key_base and dst_sel; go to ARK next cycle.
REQ-022 IDLE, start=1, mode=3: err=1 for exactly the next cycle; remain in IDLE; latch nothing.
REQ-023 ARK: op=1, data_reg=src, key_reg=key_base, round=0, wr_en=1, wr_reg=dst; next state ROUND (FINAL is never reached directly).
REQ-024 ROUND: op=2, data_reg=dst, key_reg=key_base+round mod 16, wr_en=1, wr_reg=dst; round increments each cycle from 1; go to FINAL after round Nr-1.
REQ-025 FINAL: op=3, round=Nr, key_reg=key_base+Nr mod 16, data_reg=dst, wr_en=1; next state DONE.
REQ-026 DONE: done=1, wr_en=0, op=0, busy=0; next state IDLE. A start in DONE is ignored.
REQ-027 busy=1 in ARK, ROUND and FINAL only.
REQ-028 Latency: start accepted at edge 0; ARK is active in cycle 1; done=1 in cycle Nr+2 (12/14/16).
REQ-029 start while busy SHALL be ignored; latched fields SHALL NOT change.
REQ-030 Key index arithmetic SHALL be modulo 2^W_IDX (e.g. key_base=12, round 5 -> register 1).
REQ-031 abort=1 in ARK/ROUND/FINAL: wr_en forced 0 combinationally in that cycle; next state IDLE; no done pulse.
REQ-032 abort in IDLE or DONE: no effect.
REQ-033 abort and start in the same cycle while in IDLE: start is honoured.
REQ-034 In IDLE: op=0, wr_en=0, round=0, data_reg=key_reg=wr_reg=0.

Reset
REQ-035 rst_n=0 at a clock edge: state IDLE, all latched fields 0, every output 0 the following cycle.
REQ-036 Reset SHALL override start and abort, including mid-operation; no done pulse follows.

Structure
REQ-037 Op encodings, the mode encodings and the Nr table SHALL live in the shared opcodes header.
REQ-038 One sub-module, aes_round_counter (load, increment, terminal-count compare against Nr), is natural; the FSM stays in aes_round_ctrl.

Verification
REQ-039 mode=0, src=0, key_base=4, dst=1: ARK in cycle 1 with key_reg=4; FINAL in cycle 11 with key_reg=14; done in cycle 12; 11 wr_en cycles.
REQ-040 mode=2, key_base=12: key_reg sequence 12,13,14,15,0,...,10; done in cycle 16.
REQ-041 mode=3 start: err pulse for one cycle, busy stays 0, no wr_en.
REQ-042 abort in round 5 of AES-192: wr_en=0 in that cycle; next cycle IDLE; no done; a new start is accepted the following cycle.
REQ-043 rst_n=0 during ROUND: next cycle all outputs 0, busy=0; start during busy changes nothing.
